// File: rtl/stc_sched.sv
// rtl/stc_sched.sv - STC gain scheduler stepping a breakpoint table along a sample sweep
// Optional STC_SCHED_RETRIG_LOCK_EN: triggers arriving during a sweep are ignored.
module stc_sched #(
    parameter int          ENTRIES      = 16,
    parameter logic [11:0] SAMPLE_LIMIT = 12'hFFF,
    parameter logic [11:0] GAIN_IDLE    = 12'h800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic        sample_en,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [11:0] cfg_idx,
    input  logic [11:0] cfg_gain,
    input  logic [4:0]  cfg_num,
    output logic [11:0] gain_out,
    output logic        sweep_active,
    output logic        sweep_done,
    output logic        cfg_err
);
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int NW = $clog2(ENTRIES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          trig_q;
    logic [11:0]   count_q, count_d;
    logic [NW-1:0] ptr_q, ptr_d;
    logic [NW-1:0] num_q, num_d;
    logic [11:0]   gain_q, gain_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [11:0]   tbl_idx_q  [ENTRIES];
    logic [11:0]   tbl_gain_q [ENTRIES];

    logic          trigger;
    logic          tbl_we;
    logic [AW-1:0] rd_addr;
    logic          hit;
    logic [NW-1:0] num_clamped;

`ifdef STC_SCHED_RETRIG_LOCK_EN
    assign trigger = trig & ~trig_q & (state_q != SWEEP);
`else
    assign trigger = trig & ~trig_q;
`endif

    // Table is frozen while sweeping so the pointer walk sees a stable schedule.
    assign tbl_we      = cfg_we && (state_q != SWEEP);
    assign rd_addr     = ptr_q[AW-1:0];
    assign hit         = (ptr_q < num_q) && (count_q == tbl_idx_q[rd_addr]);
    assign num_clamped = ({27'd0, cfg_num} > ENTRIES) ? NW'(ENTRIES) : NW'(cfg_num);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        num_d   = num_q;
        gain_d  = gain_q;
        done_d  = 1'b0;
        err_d   = cfg_we && (state_q == SWEEP);

        if (trigger) begin
            // A trigger swallows any strobe in the same cycle and suppresses completion.
            state_d = SWEEP;
            count_d = '0;
            ptr_d   = '0;
            num_d   = num_clamped;
        end else begin
            case (state_q)
                IDLE: begin
                    gain_d = GAIN_IDLE;
                end
                SWEEP: begin
                    if (sample_en) begin
                        if (hit) begin
                            gain_d = tbl_gain_q[rd_addr];
                            ptr_d  = ptr_q + NW'(1);
                        end
                        if (count_q >= SAMPLE_LIMIT) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end else begin
                            count_d = count_q + 12'd1;
                        end
                    end
                end
                HOLD: begin
                    gain_d = gain_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            trig_q  <= 1'b1;
            count_q <= '0;
            ptr_q   <= '0;
            num_q   <= '0;
            gain_q  <= GAIN_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            num_q   <= num_d;
            gain_q  <= gain_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_idx_q[i]  <= '0;
                tbl_gain_q[i] <= GAIN_IDLE;
            end
        end else if (tbl_we) begin
            tbl_idx_q[cfg_addr]  <= cfg_idx;
            tbl_gain_q[cfg_addr] <= cfg_gain;
        end
    end

    assign gain_out     = gain_q;
    assign sweep_active = (state_q == SWEEP);
    assign sweep_done   = done_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_stc_sched.sv
// tb/tb_stc_sched.sv - directed bench for stc_sched (honours STC_SCHED_RETRIG_LOCK_EN)
module tb_stc_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig;
    logic        sample_en;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_idx;
    logic [11:0] cfg_gain;
    logic [4:0]  cfg_num;
    logic [11:0] gain_out;
    logic        sweep_active;
    logic        sweep_done;
    logic        cfg_err;

    int n_cmp  = 0;
    int n_fail = 0;

    stc_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig         (trig),
        .sample_en    (sample_en),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_idx      (cfg_idx),
        .cfg_gain     (cfg_gain),
        .cfg_num      (cfg_num),
        .gain_out     (gain_out),
        .sweep_active (sweep_active),
        .sweep_done   (sweep_done),
        .cfg_err      (cfg_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        t;
        logic        se;
        logic        we;
        logic [3:0]  addr;
        logic [11:0] idx;
        logic [11:0] gain;
        logic [4:0]  num;
        logic [11:0] e_gain;
        logic        e_act;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs [7];

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] eg, input logic ea,
                       input logic ed, input logic ee);
        cmp({nm, ".gain_out"}, {20'd0, gain_out}, {20'd0, eg});
        cmp({nm, ".sweep_active"}, {31'd0, sweep_active}, {31'd0, ea});
        cmp({nm, ".sweep_done"}, {31'd0, sweep_done}, {31'd0, ed});
        cmp({nm, ".cfg_err"}, {31'd0, cfg_err}, {31'd0, ee});
    endtask

    task automatic drive(input logic t, input logic se, input logic we, input logic [3:0] a,
                         input logic [11:0] ix, input logic [11:0] g, input logic [4:0] n);
        trig      = t;
        sample_en = se;
        cfg_we    = we;
        cfg_addr  = a;
        cfg_idx   = ix;
        cfg_gain  = g;
        cfg_num   = n;
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
    endtask

    task automatic until_done(input int maxn, output int n, output logic [11:0] g1);
        n  = 0;
        g1 = 12'hxxx;
        for (int i = 0; i < maxn; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
            n++;
            if (n == 1) g1 = gain_out;
            if (sweep_done) break;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [11:0] g1;

        //          t   se  we  addr  idx     gain    num    e_gain   act  done err
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 12'd0,   12'h000, 5'd0, 12'h800, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 4'd0, 12'd0,   12'h001, 5'd0, 12'h800, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 4'd1, 12'd60,  12'h002, 5'd0, 12'h800, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd2, 12'd122, 12'h003, 5'd0, 12'h800, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 4'd0, 12'd0,   12'h000, 5'd3, 12'h800, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 4'd0, 12'd0,   12'h000, 5'd0, 12'h001, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 4'd0, 12'd0,   12'h000, 5'd0, 12'h001, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        trig = 1'b1; sample_en = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_idx = '0; cfg_gain = '0; cfg_num = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 12'h800, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Reset release with trig high, table load, first trigger and entry 0.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].t, vecs[i].se, vecs[i].we, vecs[i].addr,
                  vecs[i].idx, vecs[i].gain, vecs[i].num);
            chk($sformatf("vec%0d", i), vecs[i].e_gain, vecs[i].e_act, vecs[i].e_done, vecs[i].e_err);
        end

        // count now 2: rejected write during sweep at count 32
        strobes(30);
        drive(1'b0, 1'b1, 1'b1, 4'd1, 12'd70, 12'h0AA, 5'd0);
        chk("we_in_sweep", 12'h001, 1'b1, 1'b0, 1'b1);
        strobes(1);
        chk("err_clears", 12'h001, 1'b1, 1'b0, 1'b0);
        strobes(26);
        chk("before60", 12'h001, 1'b1, 1'b0, 1'b0);
        strobes(1);
        chk("at60", 12'h002, 1'b1, 1'b0, 1'b0);
        strobes(61);
        chk("before122", 12'h002, 1'b1, 1'b0, 1'b0);
        strobes(1);
        chk("at122", 12'h003, 1'b1, 1'b0, 1'b0);
        strobes(3972);
        chk("at4094", 12'h003, 1'b1, 1'b0, 1'b0);
        strobes(1);
        chk("done", 12'h003, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
        chk("hold", 12'h003, 1'b0, 1'b0, 1'b0);
        strobes(1);
        chk("hold_strobe", 12'h003, 1'b0, 1'b0, 1'b0);

        // Restart from HOLD, then re-trigger at count 200.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd3);
        chk("retrigger_hold", 12'h003, 1'b1, 1'b0, 1'b0);
        strobes(1);
        chk("restart_entry0", 12'h001, 1'b1, 1'b0, 1'b0);
        strobes(199);
        chk("at200", 12'h003, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 12'd0, 12'd0, 5'd3);
        chk("retrig200", 12'h003, 1'b1, 1'b0, 1'b0);
        until_done(5000, n, g1);
`ifdef STC_SCHED_RETRIG_LOCK_EN
        cmp("retrig200.strobes_to_done", n, 3895);
        cmp("retrig200.first_gain", {20'd0, g1}, {20'd0, 12'h003});
`else
        cmp("retrig200.strobes_to_done", n, 4096);
        cmp("retrig200.first_gain", {20'd0, g1}, {20'd0, 12'h001});
`endif
        chk("retrig200.end", 12'h003, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);

        // Trigger coinciding with the final strobe.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd3);
        strobes(4095);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 12'd0, 12'd0, 5'd3);
`ifdef STC_SCHED_RETRIG_LOCK_EN
        chk("trig_final", 12'h003, 1'b0, 1'b1, 1'b0);
`else
        chk("trig_final", 12'h003, 1'b1, 1'b0, 1'b0);
        until_done(5000, n, g1);
        cmp("trig_final.strobes_to_done", n, 4096);
`endif
        drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);

        // Descending entries; trigger shares the cycle with the last write.
        drive(1'b0, 1'b0, 1'b1, 4'd0, 12'd100, 12'h00A, 5'd0);
        chk("wr_hold", 12'h003, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd1, 12'd50, 12'h00B, 5'd2);
        chk("wr_trig", 12'h003, 1'b1, 1'b0, 1'b0);
        strobes(100);
        chk("desc_before100", 12'h003, 1'b1, 1'b0, 1'b0);
        strobes(1);
        chk("desc_at100", 12'h00A, 1'b1, 1'b0, 1'b0);
        until_done(5000, n, g1);
        cmp("desc.strobes_to_done", n, 3995);
        chk("desc.end", 12'h00A, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);

        // Empty table leaves gain untouched.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
        until_done(5000, n, g1);
        cmp("num0.strobes_to_done", n, 4096);
        cmp("num0.first_gain", {20'd0, g1}, {20'd0, 12'h00A});
        chk("num0.end", 12'h00A, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);

        // Asynchronous reset mid-sweep.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
        strobes(10);
        chk("pre_reset", 12'h00A, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #2;
        chk("async_reset", 12'h800, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
        chk("in_reset", 12'h800, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 12'd0, 5'd0);
        chk("post_reset", 12'h800, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stc_sched.md
STC_SCHED -- requirements
Module: stc_sched

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning), one per line:
  - ENTRIES, 16: breakpoint table depth.
  - SAMPLE_LIMIT, 12'hFFF: last sample index of a sweep.
  - GAIN_IDLE, 12'h800: gain word driven before the first sweep and with an empty table (unity).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line; it has one clock, and reset is asynchronous and active-low:
  - clk, in, 1: the single clock (50 MHz).
  - rst_n, in, 1: asynchronous active-low reset.
  - trig, in, 1: transmit trigger; a sweep starts on its synchronous rising edge.
  - sample_en, in, 1: sample strobe; the sample counter advances when high.
  - cfg_we, in, 1: table write strobe.
  - cfg_addr, in, 4: table entry address.
  - cfg_idx, in, 12: sample index of the breakpoint.
  - cfg_gain, in, 12: gain word applied at that breakpoint.
  - cfg_num, in, 5: number of valid entries, 0..16; sampled at sweep start.
  - gain_out, out, 12: gain/shift-control word to the STC datapath.
  - sweep_active, out, 1: high during SWEEP.
  - sweep_done, out, 1: one-cycle pulse at the natural end of a sweep.
  - cfg_err, out, 1: one-cycle pulse when a write is rejected.

Function
REQ-003 The block SHALL implement states IDLE (after reset), SWEEP and HOLD.
REQ-004 The block SHALL register trig into trig_q and define a trigger as trig & ~trig_q.
REQ-005 On a trigger in any state, the block SHALL next cycle enter SWEEP with count=0, ptr=0, and num latched from cfg_num clamped to ENTRIES.
REQ-006 In SWEEP, on each sample_en cycle, if ptr<num and count==table[ptr].idx, the block SHALL register gain_out<=table[ptr].gain and ptr<=ptr+1, giving one-cycle latency from the matching strobe.
REQ-007 Only one entry SHALL be applied per strobe; the pointer advances on exact match only, so a non-ascending or duplicate entry stalls the pointer and later entries are never applied.
REQ-008 The counter SHALL increment by 1 per sample_en and never exceed SAMPLE_LIMIT.
REQ-009 A strobe with count==SAMPLE_LIMIT SHALL evaluate the match, then enter HOLD and pulse sweep_done for one cycle.
REQ-010 When num==0, gain_out SHALL stay unchanged for the whole sweep.
REQ-011 HOLD SHALL keep the last gain_out until the next trigger; IDLE SHALL drive GAIN_IDLE.
REQ-012 A trigger and a sample_en in the same cycle SHALL resolve to the trigger; that strobe is discarded and the count is not advanced.
REQ-013 A trigger in the same cycle as the final strobe SHALL restart the sweep and SHALL NOT pulse sweep_done.
REQ-014 cfg_we in IDLE or HOLD SHALL write entry cfg_addr at the clock edge; a trigger in the same cycle SHALL use the newly written value.
REQ-015 cfg_we in SWEEP SHALL be ignored and SHALL pulse cfg_err the next cycle.

Reset
REQ-016 Asserting rst_n low SHALL immediately force the following, including mid-sweep with no completion pulse:
  - state=IDLE, count=0, ptr=0, num=0.
  - trig_q=1, so a trig held high through reset does not fire.
  - gain_out=GAIN_IDLE.
  - sweep_active=0, sweep_done=0, cfg_err=0.
  - all table entries {idx=0, gain=GAIN_IDLE}.

Configuration
REQ-017 When STC_SCHED_RETRIG_LOCK_EN is defined, triggers arriving in SWEEP SHALL be ignored; triggers in IDLE or HOLD behave per REQ-005.
REQ-018 When STC_SCHED_RETRIG_LOCK_EN is undefined, a trigger in SWEEP SHALL restart per REQ-005 and REQ-013.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  - Reset release with trig=1 -> no sweep; gain_out=12'h800, sweep_active=0.
  - Write {0:(0,001),1:(60,002),2:(122,003)}, cfg_num=3, trigger, continuous sample_en:
    - gain_out=001 one cycle after the count=0 strobe;
    - gain_out=002 after count=60;
    - gain_out=003 after count=122.
  - Same sweep to count 4095 -> single sweep_done pulse, state HOLD, gain_out stays 003; a new trigger restarts with gain from entry 0.
  - cfg_we during SWEEP (addr 1, idx 70) -> cfg_err pulse; entry 1 still applied at count 60.
  - Re-trigger at count 200:
    - macro undefined -> count restarts at 0, no sweep_done;
    - macro defined -> trigger ignored, sweep finishes at 4095.
  - Entries (100,A),(50,B), num=2 -> A applied at 100; B is never applied; sweep_done still pulses at 4095.
